// File: rtl/types_pkg.sv
// Shared types for the front-end fetch controller: FSM states, redirect bundle,
// flush counter width.
package types_pkg;

    localparam int FLUSH_CNT_W = 4;
    localparam int REDIR_PC_W  = 32;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } fctrl_state_e;

    typedef struct packed {
        logic                  valid;
        logic [REDIR_PC_W-1:0] pc;
    } redirect_t;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return |lo;
    endfunction

endpackage

// File: rtl/fetch_ctrl_flush_counter.sv
// Flush window counter: loads on redirect, counts down to zero, and exposes
// whether the window will still be open after the current edge.
import types_pkg::*;

module fetch_ctrl_flush_counter #(
    parameter int W = FLUSH_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_busy,
    output logic         o_busy_next
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_busy      = (r_cnt != '0);
    assign o_busy_next = i_load ? (i_load_val != '0) : (r_cnt > W'(1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: advances the PC on accepted fetches, redirects with epoch
// toggle and a fixed flush window, and supports debug halt/resume.
import types_pkg::*;

module fetch_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_ready,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            epoch_o,
    output logic            flush_o,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic            halted_o,
    output logic            misalign_o
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LD = FLUSH_CNT_W'(FLUSH_CYCLES);

    fctrl_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_epoch;
    logic            r_misalign;
    logic            r_halt_pend;
    logic            r_halted;

    redirect_t       w_redir;
    logic [XLEN-1:0] w_tgt_pc;
    logic            w_busy;
    logic            w_busy_next;

    // Redirect target travels at package width; word-align before loading.
    assign w_redir.valid = redirect_valid;
    assign w_redir.pc    = REDIR_PC_W'(redirect_pc);
    assign w_tgt_pc      = XLEN'({w_redir.pc[REDIR_PC_W-1:2], 2'b00});

    fetch_ctrl_flush_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
        .clk         (clk),
        .rst         (reset),
        .i_load      (w_redir.valid),
        .i_load_val  (FLUSH_LD),
        .o_busy      (w_busy),
        .o_busy_next (w_busy_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_epoch     <= 1'b0;
            r_misalign  <= 1'b0;
            r_halt_pend <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            // Redirect beats a same-cycle accepted fetch.
            if (w_redir.valid) begin
                r_pc    <= w_tgt_pc;
                r_epoch <= ~r_epoch;
                if (is_misaligned(w_redir.pc[1:0]))
                    r_misalign <= 1'b1;
            end else if (r_state == ST_RUN && fetch_ready) begin
                r_pc <= r_pc + XLEN'(4);
            end

            case (r_state)
                ST_RUN: begin
                    if (w_redir.valid) begin
                        r_state     <= ST_FLUSH;
                        r_halt_pend <= halt_req;
                    end else if (halt_req) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!w_busy_next) begin
                        r_halt_pend <= 1'b0;
                        if (r_halt_pend || halt_req) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (halt_req) begin
                        r_halt_pend <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    // A flush window still running finishes before fetch resumes.
                    if (resume_req && !halt_req) begin
                        r_halted <= 1'b0;
                        r_state  <= w_busy_next ? ST_FLUSH : ST_RUN;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid_o = (r_state == ST_RUN) & ~reset;
    assign fetch_pc_o    = r_pc;
    assign epoch_o       = r_epoch;
    assign flush_o       = w_busy;
    assign halted_o      = r_halted;
    assign misalign_o    = r_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: accepted fetches are checked against queued
// expected {pc, epoch}; control outputs are checked directly at the falling edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        resume_req = 1'b0;
    logic        fetch_valid_o, epoch_o, flush_o, halted_o, misalign_o;
    logic [31:0] fetch_pc_o;

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_ready    (fetch_ready),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_pc_o     (fetch_pc_o),
        .epoch_o        (epoch_o),
        .flush_o        (flush_o),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .halted_o       (halted_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ep;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] pc, input logic ep);
        exp_t e;
        e.pc = pc;
        e.ep = ep;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Accepted fetch: valid & ready with no redirect overriding it.
    always @(negedge clk) begin
        if (!reset && fetch_valid_o && fetch_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", 64'(fetch_pc_o), 64'(e.pc));
                chk("sb_epoch", 64'(epoch_o), 64'(e.ep));
            end
        end
    end

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 64'(fetch_pc_o), 64'h0);
        chk("rst_epoch", 64'(epoch_o), 64'd0);
        chk("rst_flush", 64'(flush_o), 64'd0);
        chk("rst_halted", 64'(halted_o), 64'd0);
        chk("rst_misalign", 64'(misalign_o), 64'd0);
        chk("rst_valid", 64'(fetch_valid_o), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Sequential fetch from reset PC
        push(32'h0, 1'b0); push(32'h4, 1'b0); push(32'h8, 1'b0); push(32'hC, 1'b0);
        fetch_ready = 1'b1;
        repeat (4) tick();

        // Redirect with same-cycle fetch_ready: PC+4 discarded
        redir(32'h100);
        fetch_ready = 1'b0;
        @(negedge clk);
        chk("r1_flush_c1", 64'(flush_o), 64'd1);
        chk("r1_valid_c1", 64'(fetch_valid_o), 64'd0);
        chk("r1_epoch", 64'(epoch_o), 64'd1);
        tick();
        @(negedge clk);
        chk("r1_flush_c2", 64'(flush_o), 64'd1);
        chk("r1_valid_c2", 64'(fetch_valid_o), 64'd0);
        tick();
        @(negedge clk);
        chk("r1_flush_end", 64'(flush_o), 64'd0);
        chk("r1_valid_back", 64'(fetch_valid_o), 64'd1);
        chk("r1_pc", 64'(fetch_pc_o), 64'h100);
        chk("r1_misalign", 64'(misalign_o), 64'd0);
        tick();
        push(32'h100, 1'b1);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;

        // Redirect again during the first flush cycle: window restarts
        redir(32'h180);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        chk("r2_flush_c1", 64'(flush_o), 64'd1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("r2_flush_c2", 64'(flush_o), 64'd1);
        tick();
        @(negedge clk);
        chk("r2_flush_c3", 64'(flush_o), 64'd1);
        chk("r2_valid_c3", 64'(fetch_valid_o), 64'd0);
        tick();
        @(negedge clk);
        chk("r2_flush_end", 64'(flush_o), 64'd0);
        chk("r2_valid_back", 64'(fetch_valid_o), 64'd1);
        chk("r2_epoch", 64'(epoch_o), 64'd1);
        chk("r2_pc", 64'(fetch_pc_o), 64'h200);
        tick();
        push(32'h200, 1'b1);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;

        // Misaligned target: aligned PC, sticky flag
        redir(32'h103);
        tick();
        tick();
        @(negedge clk);
        chk("mis_pc", 64'(fetch_pc_o), 64'h100);
        chk("mis_epoch", 64'(epoch_o), 64'd0);
        chk("mis_flag", 64'(misalign_o), 64'd1);
        repeat (10) tick();
        @(negedge clk);
        chk("mis_sticky", 64'(misalign_o), 64'd1);

        // PC wrap, then halt with in-cycle fetch, hold, resume
        redir(32'hFFFF_FFFC);
        tick();
        tick();
        push(32'hFFFF_FFFC, 1'b1);
        push(32'h0, 1'b1);
        fetch_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("wrap_pc", 64'(fetch_pc_o), 64'h0);
        #1 halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        @(negedge clk);
        chk("halt_flag", 64'(halted_o), 64'd1);
        chk("halt_valid", 64'(fetch_valid_o), 64'd0);
        chk("halt_pc", 64'(fetch_pc_o), 64'h4);
        repeat (3) tick();
        @(negedge clk);
        chk("halt_pc_hold", 64'(fetch_pc_o), 64'h4);
        #1 resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        push(32'h4, 1'b1);
        @(negedge clk);
        chk("resume_valid", 64'(fetch_valid_o), 64'd1);
        chk("resume_halted", 64'(halted_o), 64'd0);
        tick();
        fetch_ready = 1'b0;

        // Redirect while halted: flush pulses, state stays halted
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        redir(32'h400);
        @(negedge clk);
        chk("hr_flush", 64'(flush_o), 64'd1);
        chk("hr_halted", 64'(halted_o), 64'd1);
        chk("hr_valid", 64'(fetch_valid_o), 64'd0);
        tick();
        tick();
        @(negedge clk);
        chk("hr_flush_end", 64'(flush_o), 64'd0);
        chk("hr_still_halted", 64'(halted_o), 64'd1);
        chk("hr_pc", 64'(fetch_pc_o), 64'h400);
        #1 resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        @(negedge clk);
        chk("hr_resume_valid", 64'(fetch_valid_o), 64'd1);
        chk("hr_epoch", 64'(epoch_o), 64'd0);

        // Asynchronous reset in the middle of a flush
        #1;
        redir(32'h300);
        @(negedge clk);
        chk("ar_flush_pre", 64'(flush_o), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("ar_flush", 64'(flush_o), 64'd0);
        chk("ar_pc", 64'(fetch_pc_o), 64'h0);
        chk("ar_epoch", 64'(epoch_o), 64'd0);
        chk("ar_misalign", 64'(misalign_o), 64'd0);
        chk("ar_valid", 64'(fetch_valid_o), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
